// File: rtl/fetch_packet_queue_pkg.sv
// Shared packet layout and constants for the fetch packet queue.
// Field widths default here unless the surrounding build already defines them.
`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

package fetch_packet_queue_pkg;

   localparam int FETCH_BANDWIDTH  = 4;
   localparam int SIZE_INSTRUCTION = `SIZE_INSTRUCTION;
   localparam int SIZE_PC          = `SIZE_PC;
   localparam int SIZE_CTI_LOG     = `SIZE_CTI_LOG;
   localparam int PKT_W            = `SIZE_INSTRUCTION + 2*`SIZE_PC + `SIZE_CTI_LOG + 1;

   typedef struct packed {
      logic [SIZE_INSTRUCTION-1:0] instruction;
      logic [SIZE_PC-1:0]          pc;
      logic [SIZE_PC-1:0]          targetAddr;
      logic [SIZE_CTI_LOG-1:0]     ctiqTag;
      logic                        prediction;
   } fetch_packet_t;

   // Length of the contiguous valid run starting at slot 0 (bit 0).
   function automatic logic [2:0] lead_valid_count(input logic [FETCH_BANDWIDTH-1:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = FETCH_BANDWIDTH-1; i >= 0; i--) begin
         n = v[i] ? n + 3'd1 : 3'd0;
      end
      return n;
   endfunction

endpackage

// File: rtl/fetch_packet_queue_ram.sv
// Register-file storage for the fetch packet queue: 4 write ports, 4 async read ports.
// No reset; validity of contents is tracked entirely by the queue pointers.
module fpq_ram_4w4r #(
   parameter int DEPTH = 16,
   parameter int PKT_W = 101,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                                                  clk,
   input  logic [fetch_packet_queue_pkg::FETCH_BANDWIDTH-1:0]              wr_en,
   input  logic [fetch_packet_queue_pkg::FETCH_BANDWIDTH-1:0][AW-1:0]      wr_addr,
   input  logic [fetch_packet_queue_pkg::FETCH_BANDWIDTH-1:0][PKT_W-1:0]   wr_data,
   input  logic [fetch_packet_queue_pkg::FETCH_BANDWIDTH-1:0][AW-1:0]      rd_addr,
   output logic [fetch_packet_queue_pkg::FETCH_BANDWIDTH-1:0][PKT_W-1:0]   rd_data
);
   import fetch_packet_queue_pkg::*;

   logic [PKT_W-1:0] mem [DEPTH];

   // Write addresses within one bundle are always distinct, so port order never matters.
   always_ff @(posedge clk) begin
      for (int p = 0; p < FETCH_BANDWIDTH; p++) begin
         if (wr_en[p]) mem[wr_addr[p]] <= wr_data[p];
      end
   end

   always_comb begin
      for (int k = 0; k < FETCH_BANDWIDTH; k++) begin
         rd_data[k] = mem[rd_addr[k]];
      end
   end

endmodule

// File: rtl/fetch_packet_queue.sv
// Circular queue between fetch stage 2 and decode, up to 4 packets in and out per cycle.
// Define FETCH_PACKET_QUEUE_BYPASS_EN to forward packets arriving at an empty queue in the same cycle.
module fetch_packet_queue #(
   parameter int DEPTH = 16,
   parameter int PKT_W = fetch_packet_queue_pkg::PKT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     fs2Ready_i,
   input  logic                     inst0Valid_i,
   input  logic                     inst1Valid_i,
   input  logic                     inst2Valid_i,
   input  logic                     inst3Valid_i,
   input  logic [PKT_W-1:0]         inst0Packet_i,
   input  logic [PKT_W-1:0]         inst1Packet_i,
   input  logic [PKT_W-1:0]         inst2Packet_i,
   input  logic [PKT_W-1:0]         inst3Packet_i,
   input  logic                     decodeReady_i,
   output logic [PKT_W-1:0]         inst0Packet_o,
   output logic [PKT_W-1:0]         inst1Packet_o,
   output logic [PKT_W-1:0]         inst2Packet_o,
   output logic [PKT_W-1:0]         inst3Packet_o,
   output logic                     inst0Valid_o,
   output logic                     inst1Valid_o,
   output logic                     inst2Valid_o,
   output logic                     inst3Valid_o,
   output logic                     stallFetch_o,
   output logic [$clog2(DEPTH):0]   occupancy_o
);
   import fetch_packet_queue_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_ptr, tail_ptr;
   logic [CNT_W-1:0] count;

   logic [FETCH_BANDWIDTH-1:0]              in_valid;
   logic [FETCH_BANDWIDTH-1:0][PKT_W-1:0]   in_pkt;
   logic [FETCH_BANDWIDTH-1:0]              out_valid;
   logic [FETCH_BANDWIDTH-1:0][PKT_W-1:0]   out_pkt;

   logic [FETCH_BANDWIDTH-1:0]              wr_en;
   logic [FETCH_BANDWIDTH-1:0][PTR_W-1:0]   wr_addr;
   logic [FETCH_BANDWIDTH-1:0][PTR_W-1:0]   rd_addr;
   logic [FETCH_BANDWIDTH-1:0][PKT_W-1:0]   rd_data;

   logic       enq_ok;
   logic [2:0] n_enq, n_write, n_deq;
   logic       bypass_hit, bypass_consume;

   assign in_valid = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
   assign in_pkt   = {inst3Packet_i, inst2Packet_i, inst1Packet_i, inst0Packet_i};

   // Stall on registered count only, so a whole bundle always fits once accepted.
   assign stallFetch_o = (CNT_W'(DEPTH) - count) < CNT_W'(FETCH_BANDWIDTH);
   assign enq_ok       = fs2Ready_i & ~stallFetch_o & ~flush_i;
   assign n_enq        = enq_ok ? lead_valid_count(in_valid) : 3'd0;

`ifdef FETCH_PACKET_QUEUE_BYPASS_EN
   assign bypass_hit = (count == '0) & fs2Ready_i & ~flush_i;
`else
   assign bypass_hit = 1'b0;
`endif
   assign bypass_consume = bypass_hit & decodeReady_i;
   assign n_write        = bypass_consume ? 3'd0 : n_enq;

   always_comb begin
      n_deq = 3'd0;
      if (decodeReady_i && !flush_i) begin
         n_deq = (count >= CNT_W'(FETCH_BANDWIDTH)) ? 3'd4 : count[2:0];
      end
   end

   always_comb begin
      for (int p = 0; p < FETCH_BANDWIDTH; p++) begin
         wr_en[p]   = ~reset & (3'(p) < n_write);
         wr_addr[p] = tail_ptr + PTR_W'(p);
         rd_addr[p] = head_ptr + PTR_W'(p);
      end
   end

   fpq_ram_4w4r #(
      .DEPTH (DEPTH),
      .PKT_W (PKT_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (in_pkt),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         head_ptr <= head_ptr + PTR_W'(n_deq);
         tail_ptr <= tail_ptr + PTR_W'(n_write);
         count    <= count + CNT_W'(n_write) - CNT_W'(n_deq);
      end
   end

   // An empty queue shows nothing from storage, so bypass can simply override.
   always_comb begin
      for (int k = 0; k < FETCH_BANDWIDTH; k++) begin
         out_valid[k] = count > CNT_W'(k);
         out_pkt[k]   = rd_data[k];
         if (bypass_hit) begin
            out_valid[k] = 3'(k) < n_enq;
            out_pkt[k]   = in_pkt[k];
         end
      end
   end

   assign inst0Valid_o  = out_valid[0];
   assign inst1Valid_o  = out_valid[1];
   assign inst2Valid_o  = out_valid[2];
   assign inst3Valid_o  = out_valid[3];
   assign inst0Packet_o = out_pkt[0];
   assign inst1Packet_o = out_pkt[1];
   assign inst2Packet_o = out_pkt[2];
   assign inst3Packet_o = out_pkt[3];
   assign occupancy_o   = count;

endmodule

// File: tb/tb_fetch_packet_queue.sv
// Directed self-checking bench for fetch_packet_queue (DEPTH = 16).
// Masks are written slot 0 first: 4'b1011 means slot0=1, slot1=0, slot2=1, slot3=1.
module tb_fetch_packet_queue;
   import fetch_packet_queue_pkg::*;

   logic clk = 1'b0;
   logic reset, flush_i, fs2Ready_i, decodeReady_i;
   logic inst0Valid_i, inst1Valid_i, inst2Valid_i, inst3Valid_i;
   logic [PKT_W-1:0] inst0Packet_i, inst1Packet_i, inst2Packet_i, inst3Packet_i;
   logic [PKT_W-1:0] inst0Packet_o, inst1Packet_o, inst2Packet_o, inst3Packet_o;
   logic inst0Valid_o, inst1Valid_o, inst2Valid_o, inst3Valid_o;
   logic stallFetch_o;
   logic [4:0] occupancy_o;

   int checks = 0;
   int errors = 0;

   fetch_packet_t o0, o1, o2, o3;
   logic [3:0]  out_v;
   logic [127:0] out_pc;
   assign o0 = inst0Packet_o;
   assign o1 = inst1Packet_o;
   assign o2 = inst2Packet_o;
   assign o3 = inst3Packet_o;
   assign out_v  = {inst0Valid_o, inst1Valid_o, inst2Valid_o, inst3Valid_o};
   assign out_pc = {o0.pc, o1.pc, o2.pc, o3.pc};

   fetch_packet_queue #(.DEPTH(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .flush_i       (flush_i),
      .fs2Ready_i    (fs2Ready_i),
      .inst0Valid_i  (inst0Valid_i),
      .inst1Valid_i  (inst1Valid_i),
      .inst2Valid_i  (inst2Valid_i),
      .inst3Valid_i  (inst3Valid_i),
      .inst0Packet_i (inst0Packet_i),
      .inst1Packet_i (inst1Packet_i),
      .inst2Packet_i (inst2Packet_i),
      .inst3Packet_i (inst3Packet_i),
      .decodeReady_i (decodeReady_i),
      .inst0Packet_o (inst0Packet_o),
      .inst1Packet_o (inst1Packet_o),
      .inst2Packet_o (inst2Packet_o),
      .inst3Packet_o (inst3Packet_o),
      .inst0Valid_o  (inst0Valid_o),
      .inst1Valid_o  (inst1Valid_o),
      .inst2Valid_o  (inst2Valid_o),
      .inst3Valid_o  (inst3Valid_o),
      .stallFetch_o  (stallFetch_o),
      .occupancy_o   (occupancy_o)
   );

   always #5 clk = ~clk;

   function automatic fetch_packet_t mk(input logic [31:0] pc);
      fetch_packet_t p;
      p.instruction = pc ^ 32'hA5A5_0000;
      p.pc          = pc;
      p.targetAddr  = pc + 32'd4;
      p.ctiqTag     = pc[3:0];
      p.prediction  = pc[0];
      return p;
   endfunction

   task automatic drive(input logic [3:0] mask, input logic [31:0] base,
                        input logic fs, input logic dr, input logic fl);
      inst0Valid_i  = mask[3];
      inst1Valid_i  = mask[2];
      inst2Valid_i  = mask[1];
      inst3Valid_i  = mask[0];
      inst0Packet_i = mk(base);
      inst1Packet_i = mk(base + 32'd1);
      inst2Packet_i = mk(base + 32'd2);
      inst3Packet_i = mk(base + 32'd3);
      fs2Ready_i    = fs;
      decodeReady_i = dr;
      flush_i       = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      checks++; if (out_v !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b exp=0000", out_v); end
      checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
      checks++; if (stallFetch_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stallFetch_o); end
      tick();
      checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL idle_occ got=%0d exp=0", occupancy_o); end
   endtask

   task automatic test_enqueue();
      drive(4'b1111, 32'h100, 1'b1, 1'b0, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd4) begin errors++; $display("FAIL enq1111_occ got=%0d exp=4", occupancy_o); end
      drive(4'b1100, 32'h110, 1'b1, 1'b0, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd6) begin errors++; $display("FAIL enq1100_occ got=%0d exp=6", occupancy_o); end
      drive(4'b1000, 32'h120, 1'b1, 1'b0, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd7) begin errors++; $display("FAIL enq1000_occ got=%0d exp=7", occupancy_o); end
      checks++; if (stallFetch_o !== 1'b0) begin errors++; $display("FAIL occ7_stall got=%b exp=0", stallFetch_o); end
      checks++; if (out_v !== 4'b1111) begin errors++; $display("FAIL enq_valid got=%b exp=1111", out_v); end
      checks++; if (out_pc !== {32'h100, 32'h101, 32'h102, 32'h103}) begin errors++; $display("FAIL enq_order got=%h exp=100..103", out_pc); end
      checks++; if (inst1Packet_o !== PKT_W'(mk(32'h101))) begin errors++; $display("FAIL enq_pkt1 got=%h exp=%h", inst1Packet_o, mk(32'h101)); end
   endtask

   task automatic test_stall();
      drive(4'b1111, 32'h130, 1'b1, 1'b0, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd11) begin errors++; $display("FAIL fill11_occ got=%0d exp=11", occupancy_o); end
      drive(4'b1000, 32'h140, 1'b1, 1'b0, 1'b0); tick();
      checks++; if ({occupancy_o, stallFetch_o} !== {5'd12, 1'b0}) begin errors++; $display("FAIL occ12_stall got=%0d/%b exp=12/0", occupancy_o, stallFetch_o); end
      drive(4'b1000, 32'h150, 1'b1, 1'b0, 1'b0); tick();
      checks++; if ({occupancy_o, stallFetch_o} !== {5'd13, 1'b1}) begin errors++; $display("FAIL occ13_stall got=%0d/%b exp=13/1", occupancy_o, stallFetch_o); end
      drive(4'b1111, 32'h160, 1'b1, 1'b0, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd13) begin errors++; $display("FAIL stall_block_occ got=%0d exp=13", occupancy_o); end
      drive(4'b0000, 32'h0, 1'b0, 1'b1, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd9) begin errors++; $display("FAIL deq4_occ got=%0d exp=9", occupancy_o); end
      checks++; if (out_pc !== {32'h110, 32'h111, 32'h120, 32'h130}) begin errors++; $display("FAIL deq4_order got=%h exp=110,111,120,130", out_pc); end
      checks++; if (stallFetch_o !== 1'b0) begin errors++; $display("FAIL deq4_stall got=%b exp=0", stallFetch_o); end
   endtask

   task automatic test_noncontig();
      drive(4'b1011, 32'h170, 1'b1, 1'b0, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd10) begin errors++; $display("FAIL mask1011_occ got=%0d exp=10", occupancy_o); end
      drive(4'b1111, 32'h180, 1'b0, 1'b0, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd10) begin errors++; $display("FAIL fs2notready_occ got=%0d exp=10", occupancy_o); end
   endtask

   task automatic test_flush();
      drive(4'b1111, 32'h190, 1'b1, 1'b1, 1'b1); tick();
      checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy_o); end
      checks++; if (out_v !== 4'b0000) begin errors++; $display("FAIL flush_valid got=%b exp=0000", out_v); end
      checks++; if (stallFetch_o !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stallFetch_o); end
   endtask

   // Walks head to entry 14 with four live entries, then enqueues and dequeues four at once.
   task automatic test_wrap();
      drive(4'b1111, 32'h200, 1'b1, 1'b0, 1'b0); tick();
      drive(4'b1111, 32'h210, 1'b1, 1'b1, 1'b0); tick();
      drive(4'b1111, 32'h220, 1'b1, 1'b1, 1'b0); tick();
      drive(4'b1100, 32'h230, 1'b1, 1'b1, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd2) begin errors++; $display("FAIL wrap_prep_occ got=%0d exp=2", occupancy_o); end
      drive(4'b1100, 32'h240, 1'b1, 1'b1, 1'b0); tick();
      drive(4'b1100, 32'h250, 1'b1, 1'b0, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd4) begin errors++; $display("FAIL wrap_head14_occ got=%0d exp=4", occupancy_o); end
      checks++; if (out_pc !== {32'h240, 32'h241, 32'h250, 32'h251}) begin errors++; $display("FAIL wrap_read got=%h exp=240,241,250,251", out_pc); end
      drive(4'b1111, 32'h260, 1'b1, 1'b1, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd4) begin errors++; $display("FAIL wrap_simul_occ got=%0d exp=4", occupancy_o); end
      checks++; if (out_pc !== {32'h260, 32'h261, 32'h262, 32'h263}) begin errors++; $display("FAIL wrap_simul_order got=%h exp=260..263", out_pc); end
      checks++; if (out_v !== 4'b1111) begin errors++; $display("FAIL wrap_simul_valid got=%b exp=1111", out_v); end
   endtask

   task automatic test_bypass();
      drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b1); tick();
      drive(4'b1110, 32'h300, 1'b1, 1'b1, 1'b0);
      #1;
`ifdef FETCH_PACKET_QUEUE_BYPASS_EN
      checks++; if (out_v !== 4'b1110) begin errors++; $display("FAIL bypass_valid got=%b exp=1110", out_v); end
      checks++; if (out_pc[127:32] !== {32'h300, 32'h301, 32'h302}) begin errors++; $display("FAIL bypass_pc got=%h exp=300,301,302", out_pc[127:32]); end
      tick();
      checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL bypass_consumed_occ got=%0d exp=0", occupancy_o); end
      drive(4'b1100, 32'h310, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (out_v !== 4'b1100) begin errors++; $display("FAIL bypass_nodeq_valid got=%b exp=1100", out_v); end
      tick();
      checks++; if (occupancy_o !== 5'd2) begin errors++; $display("FAIL bypass_nodeq_occ got=%0d exp=2", occupancy_o); end
      checks++; if (o0.pc !== 32'h310) begin errors++; $display("FAIL bypass_nodeq_pc got=%h exp=310", o0.pc); end
`else
      checks++; if (out_v !== 4'b0000) begin errors++; $display("FAIL nobypass_same_cycle got=%b exp=0000", out_v); end
      tick();
      checks++; if (occupancy_o !== 5'd3) begin errors++; $display("FAIL nobypass_occ got=%0d exp=3", occupancy_o); end
      checks++; if (out_v !== 4'b1110) begin errors++; $display("FAIL nobypass_valid got=%b exp=1110", out_v); end
      checks++; if (o0.pc !== 32'h300) begin errors++; $display("FAIL nobypass_pc got=%h exp=300", o0.pc); end
`endif
   endtask

   task automatic test_reset_mid();
      drive(4'b1111, 32'h400, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL midreset_occ got=%0d exp=0", occupancy_o); end
      checks++; if (out_v !== 4'b0000) begin errors++; $display("FAIL midreset_valid got=%b exp=0000", out_v); end
      drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b0); tick();
      checks++; if (occupancy_o !== 5'd0) begin errors++; $display("FAIL midreset_idle_occ got=%0d exp=0", occupancy_o); end
   endtask

   initial begin
      reset = 1'b1;
      drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_enqueue();
      test_stall();
      test_noncontig();
      test_flush();
      test_wrap();
      test_bypass();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
